sld_vjtag: RTL and testbench

SLD_VJTAG -- requirements
Module: sld_vjtag

---
 rtl/sld_vjtag_if.sv | 45 ++++
 rtl/sld_vjtag.sv | 108 ++++++++++
 tb/tb_sld_vjtag.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sld_vjtag_if.sv
// ---------------------------------------------------------------------------
// sld_vjtag_if -- signal bundle between a virtual-JTAG hub (slave) and the
// logic driving/observing it (master).
//
//   tms, tdi          : TAP mode select / serial data in (master -> slave)
//   tdo_user          : user DR serial out, routed to tdo in Shift-DR
//   ir_out            : Capture-IR load value (used with VJTAG_IR_CAPTURE_EN)
//   tdo               : serial data out (slave -> master)
//   ir_in             : current virtual instruction
//   virtual_state_*   : one-hot-or-zero TAP state flags
// ---------------------------------------------------------------------------
interface sld_vjtag_if #(
  parameter int SLD_IR_WIDTH = 4
);
  logic                    tms;
  logic                    tdi;
  logic                    tdo_user;
  logic [SLD_IR_WIDTH-1:0] ir_out;
  logic                    tdo;
  logic [SLD_IR_WIDTH-1:0] ir_in;
  logic                    virtual_state_cdr;
  logic                    virtual_state_sdr;
  logic                    virtual_state_e1dr;
  logic                    virtual_state_pdr;
  logic                    virtual_state_e2dr;
  logic                    virtual_state_udr;
  logic                    virtual_state_cir;
  logic                    virtual_state_uir;

  modport master (
    output tms, tdi, tdo_user, ir_out,
    input  tdo, ir_in,
    input  virtual_state_cdr, virtual_state_sdr, virtual_state_e1dr,
    input  virtual_state_pdr, virtual_state_e2dr, virtual_state_udr,
    input  virtual_state_cir, virtual_state_uir
  );

  modport slave (
    input  tms, tdi, tdo_user, ir_out,
    output tdo, ir_in,
    output virtual_state_cdr, virtual_state_sdr, virtual_state_e1dr,
    output virtual_state_pdr, virtual_state_e2dr, virtual_state_udr,
    output virtual_state_cir, virtual_state_uir
  );
endinterface

// File: rtl/sld_vjtag.sv
// ---------------------------------------------------------------------------
// sld_vjtag -- virtual JTAG TAP: 16-state IEEE 1149.1 controller, virtual
// instruction register and state flags for a user data register.
//
// Ports:
//   tck  : JTAG clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset (TAP to Test-Logic-Reset, IR cleared)
//   bus  : sld_vjtag_if.slave (tms, tdi, tdo_user, ir_out -> tdo, ir_in, flags)
//
// Configuration macro VJTAG_IR_CAPTURE_EN:
//   defined   : Capture-IR loads bus.ir_out
//   undefined : Capture-IR loads constant ...0001 and bus.ir_out is ignored
// ---------------------------------------------------------------------------
module sld_vjtag #(
  parameter int SLD_IR_WIDTH       = 4,
  parameter int SLD_INSTANCE_INDEX = 0
) (
  input  logic       tck,
  input  logic       rst,
  sld_vjtag_if.slave bus
);

  localparam int unused_instance_index = SLD_INSTANCE_INDEX;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  tap_state_t              state;
  tap_state_t              state_nxt;
  logic [SLD_IR_WIDTH-1:0] ir_sh;
  logic [SLD_IR_WIDTH-1:0] ir_reg;
  logic [SLD_IR_WIDTH-1:0] ir_cap;
  logic [SLD_IR_WIDTH:0]   ir_cat;

`ifdef VJTAG_IR_CAPTURE_EN
  assign ir_cap = bus.ir_out;
`else
  logic unused_ir_out;
  assign unused_ir_out = ^bus.ir_out;
  assign ir_cap        = SLD_IR_WIDTH'(1);
`endif

  // tdi on top, shifter below; bits [W:1] are the right-shifted result and
  // the expression stays legal for a 1-bit IR.
  assign ir_cat = {bus.tdi, ir_sh};

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:     state_nxt = bus.tms ? TLR    : RTI;
      RTI:     state_nxt = bus.tms ? SEL_DR : RTI;
      SEL_DR:  state_nxt = bus.tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = bus.tms ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = bus.tms ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = bus.tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_nxt = bus.tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_nxt = bus.tms ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = bus.tms ? SEL_DR : RTI;
      SEL_IR:  state_nxt = bus.tms ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = bus.tms ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = bus.tms ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = bus.tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_nxt = bus.tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_nxt = bus.tms ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = bus.tms ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      state  <= TLR;
      ir_sh  <= '0;
      ir_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CAP_IR:  ir_sh <= ir_cap;
        SH_IR:   ir_sh <= ir_cat[SLD_IR_WIDTH:1];
        default: ir_sh <= ir_sh;
      endcase
      // Update-IR never leads to TLR, so the two cases cannot collide.
      if (state_nxt == TLR)
        ir_reg <= '0;
      else if (state == UPD_IR)
        ir_reg <= ir_sh;
    end
  end

  assign bus.ir_in = ir_reg;

  // Flags and tdo decode the current state directly so they track the TAP
  // in the same cycle; in TLR (and thus during reset) all are low.
  assign bus.virtual_state_cdr  = (state == CAP_DR);
  assign bus.virtual_state_sdr  = (state == SH_DR);
  assign bus.virtual_state_e1dr = (state == EX1_DR);
  assign bus.virtual_state_pdr  = (state == PAU_DR);
  assign bus.virtual_state_e2dr = (state == EX2_DR);
  assign bus.virtual_state_udr  = (state == UPD_DR);
  assign bus.virtual_state_cir  = (state == CAP_IR);
  assign bus.virtual_state_uir  = (state == UPD_IR);

  assign bus.tdo = (state == SH_IR) ? ir_sh[0]     :
                   (state == SH_DR) ? bus.tdo_user : 1'b0;

endmodule

// File: tb/tb_sld_vjtag.sv
// ---------------------------------------------------------------------------
// tb_sld_vjtag -- testbench for sld_vjtag: directed TAP walks plus a random
// tms/tdi walk, every cycle compared against a table-driven TAP model.
// ---------------------------------------------------------------------------
module tb_sld_vjtag;

  localparam int W = 4;

  // Model state identifiers (bench-local naming).
  localparam int M_TLR = 0,  M_RTI = 1,  M_SDS = 2,  M_CDR = 3;
  localparam int M_SHD = 4,  M_E1D = 5,  M_PDR = 6,  M_E2D = 7;
  localparam int M_UDR = 8,  M_SIS = 9,  M_CIR = 10, M_SHI = 11;
  localparam int M_E1I = 12, M_PIR = 13, M_E2I = 14, M_UIR = 15;

  logic tck = 1'b0;
  logic rst = 1'b1;

  sld_vjtag_if #(.SLD_IR_WIDTH(W)) bus ();

  sld_vjtag #(.SLD_IR_WIDTH(W), .SLD_INSTANCE_INDEX(0)) dut (
    .tck (tck),
    .rst (rst),
    .bus (bus)
  );

  always #5 tck = ~tck;

  int       n_checks = 0;
  int       n_errors = 0;
  int       nxt [16][2];
  int       flg [16];
  int       m_st;
  bit [W-1:0] m_sh, m_ir;
  bit [W-1:0] ir_out_val;
  int       cnt [8];   // index 0..7 = cdr,sdr,e1dr,pdr,e2dr,udr,cir,uir

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_flags();
    return {bus.virtual_state_cdr, bus.virtual_state_sdr,
            bus.virtual_state_e1dr, bus.virtual_state_pdr,
            bus.virtual_state_e2dr, bus.virtual_state_udr,
            bus.virtual_state_cir, bus.virtual_state_uir};
  endfunction

  task automatic init_model();
    // {tms=0 target, tms=1 target} for every TAP state.
    nxt[M_TLR] = '{M_RTI, M_TLR}; nxt[M_RTI] = '{M_RTI, M_SDS};
    nxt[M_SDS] = '{M_CDR, M_SIS}; nxt[M_CDR] = '{M_SHD, M_E1D};
    nxt[M_SHD] = '{M_SHD, M_E1D}; nxt[M_E1D] = '{M_PDR, M_UDR};
    nxt[M_PDR] = '{M_PDR, M_E2D}; nxt[M_E2D] = '{M_SHD, M_UDR};
    nxt[M_UDR] = '{M_RTI, M_SDS}; nxt[M_SIS] = '{M_CIR, M_TLR};
    nxt[M_CIR] = '{M_SHI, M_E1I}; nxt[M_SHI] = '{M_SHI, M_E1I};
    nxt[M_E1I] = '{M_PIR, M_UIR}; nxt[M_PIR] = '{M_PIR, M_E2I};
    nxt[M_E2I] = '{M_SHI, M_UIR}; nxt[M_UIR] = '{M_RTI, M_SDS};
    for (int i = 0; i < 16; i++) flg[i] = 0;
    flg[M_CDR] = 8'h80; flg[M_SHD] = 8'h40; flg[M_E1D] = 8'h20;
    flg[M_PDR] = 8'h10; flg[M_E2D] = 8'h08; flg[M_UDR] = 8'h04;
    flg[M_CIR] = 8'h02; flg[M_UIR] = 8'h01;
  endtask

  function automatic bit [W-1:0] capture_value(input bit [W-1:0] iro);
`ifdef VJTAG_IR_CAPTURE_EN
    return iro;
`else
    return 1;
`endif
  endfunction

  task automatic model_reset();
    m_st = M_TLR;
    m_sh = '0;
    m_ir = '0;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
  endtask

  // One tck cycle: drive, advance model over the edge, compare after it.
  task automatic step(input bit t_ms, input bit t_di);
    bit [7:0] f;
    bit       exp_tdo;
    bus.tms      = t_ms;
    bus.tdi      = t_di;
    bus.tdo_user = 1'($urandom);
    bus.ir_out   = ir_out_val;
    @(posedge tck);
    if (m_st == M_CIR) m_sh = capture_value(ir_out_val);
    else if (m_st == M_SHI) m_sh = W'({t_di, m_sh} >> 1);
    if (m_st == M_UIR) m_ir = m_sh;
    m_st = nxt[m_st][t_ms];
    if (m_st == M_TLR) m_ir = '0;
    #1;
    f = dut_flags();
    check("flags", 32'(f), 32'(flg[m_st]));
    exp_tdo = (m_st == M_SHI) ? m_sh[0] : (m_st == M_SHD) ? bus.tdo_user : 1'b0;
    check("tdo", 32'(bus.tdo), 32'(exp_tdo));
    check("ir_in", 32'(bus.ir_in), 32'(m_ir));
    for (int i = 0; i < 8; i++) if (f[7-i]) cnt[i]++;
  endtask

  task automatic tms_seq(input bit [7:0] bits, input int n);
    for (int i = 0; i < n; i++) step(bits[i], 1'($urandom));
  endtask

  initial begin
    bit [3:0] tdo_seq;
    bit [3:0] tdo_exp;
    bit [3:0] shift_bits;

    init_model();
    model_reset();
    clr_cnt();
    ir_out_val   = 4'hA;
    bus.tms      = 1'b1;
    bus.tdi      = 1'b0;
    bus.tdo_user = 1'b1;
    bus.ir_out   = ir_out_val;

    // Reset state
    #2;
    check("rst_flags", 32'(dut_flags()), 0);
    check("rst_tdo",   32'(bus.tdo), 0);
    check("rst_ir_in", 32'(bus.ir_in), 0);
    #10 rst = 1'b0;

    // Five tms=1 edges: stay in TLR
    tms_seq(8'b0001_1111, 5);
    step(1'b0, 1'b0);                 // -> RTI

    // IR load: tms 1,1,0,0 then shift 1,0,1,0 LSB-first, Exit1, Update, RTI
    clr_cnt();
    tms_seq(8'b0000_0011, 4);         // SelDR, SelIR, CapIR, ShIR
    shift_bits = 4'b0101;             // bit i is shifted on edge i
    for (int i = 0; i < 4; i++) begin
      tdo_seq[i] = bus.tdo;
      step(i == 3, shift_bits[i]);
    end
`ifdef VJTAG_IR_CAPTURE_EN
    tdo_exp = 4'b1010;                // sequence 0,1,0,1
`else
    tdo_exp = 4'b0001;                // sequence 1,0,0,0
`endif
    check("ir_tdo_seq", 32'(tdo_seq), 32'(tdo_exp));
    step(1'b1, 1'b0);                 // UpdIR
    step(1'b0, 1'b0);                 // RTI, ir_in updated
    check("ir_load", 32'(bus.ir_in), 32'h5);
    check("uir_cycles", 32'(cnt[7]), 1);
    check("cir_cycles", 32'(cnt[6]), 1);

    // DR: capture then 32 cycles of shift
    clr_cnt();
    step(1'b1, 1'b0);                 // SelDR
    step(1'b0, 1'b0);                 // CapDR
    for (int i = 0; i < 32; i++) step(1'b0, 1'($urandom));
    check("cdr_cycles", 32'(cnt[0]), 1);
    check("sdr_cycles", 32'(cnt[1]), 32);
    check("dr_ir_hold", 32'(bus.ir_in), 32'h5);

    // Exit1, Pause x3, Exit2, Update, RTI
    clr_cnt();
    tms_seq(8'b0011_0001, 7);
    check("e1dr_cycles", 32'(cnt[2]), 1);
    check("pdr_cycles",  32'(cnt[3]), 3);
    check("e2dr_cycles", 32'(cnt[4]), 1);
    check("udr_cycles",  32'(cnt[5]), 1);

    // Reset in the middle of Shift-IR
    tms_seq(8'b0000_0011, 4);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    bus.tdo_user = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_flags", 32'(dut_flags()), 0);
    check("midrst_ir_in", 32'(bus.ir_in), 0);
    check("midrst_tdo",   32'(bus.tdo), 0);
    #1 rst = 1'b0;

    // Random walk with periodic five-ones escapes to TLR
    for (int i = 0; i < 1500; i++) begin
      ir_out_val = 4'($urandom);
      step(1'($urandom_range(0, 2) == 0), 1'($urandom));
      if (i % 150 == 149) begin
        tms_seq(8'b0001_1111, 5);
        check("tlr5_ir_in", 32'(bus.ir_in), 0);
        check("tlr5_flags", 32'(dut_flags()), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
